// File: rtl/adder_serial_loader_if.sv
// ============================================================================
// adder_serial_loader_if : serial-in / adder-side bus of adder_serial_loader
// Revision 1.0
// ============================================================================
`default_nettype none

interface adder_serial_loader_if;
  logic       bit_in;
  logic       bit_valid;
  logic       frame_start;
  logic [2:0] a_out;
  logic [2:0] b_out;
  logic       cin_out;
  logic [2:0] sum_in;
  logic       cout_in;
  logic [3:0] result;
  logic       result_valid;
  logic       busy;

  // master: serial front-end plus external adder; slave: the loader
  modport master (
    output bit_in, bit_valid, frame_start, sum_in, cout_in,
    input  a_out, b_out, cin_out, result, result_valid, busy
  );

  modport slave (
    input  bit_in, bit_valid, frame_start, sum_in, cout_in,
    output a_out, b_out, cin_out, result, result_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/adder_serial_loader.sv
// ============================================================================
// adder_serial_loader : assembles A/B/Cin from a serial stream, drives the
// 3-bit adder, and captures {C_out, Sum} after a settling window.
// Revision 1.0
// ============================================================================
`default_nettype none

module adder_serial_loader #(
  parameter int ISSUE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  adder_serial_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [2:0] ISSUE_LAST = 3'(ISSUE_CYCLES);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [2:0] issue_cnt;
  logic [2:0] a_reg;
  logic [2:0] b_reg;
  logic       cin_reg;
  logic [3:0] result_reg;
  logic       valid_reg;
  logic       busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      issue_cnt  <= 3'd0;
      a_reg      <= 3'd0;
      b_reg      <= 3'd0;
      cin_reg    <= 1'b0;
      result_reg <= 4'd0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.bit_valid) begin
            a_reg[0] <= bus.bit_in;
            bit_cnt  <= 3'd1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (bus.bit_valid) begin
            if (bus.frame_start) begin
              // Abandon the partial frame; this bit restarts at A[0]
              a_reg[0] <= bus.bit_in;
              bit_cnt  <= 3'd1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              case (bit_cnt)
                3'd1: a_reg[1] <= bus.bit_in;
                3'd2: a_reg[2] <= bus.bit_in;
                3'd3: b_reg[0] <= bus.bit_in;
                3'd4: b_reg[1] <= bus.bit_in;
                3'd5: b_reg[2] <= bus.bit_in;
                3'd6: begin
                  cin_reg   <= bus.bit_in;
                  issue_cnt <= 3'd0;
                  busy_reg  <= 1'b1;
                  state     <= ISSUE;
                end
                default: ;
              endcase
            end
          end
        end

        ISSUE: begin
          issue_cnt <= issue_cnt + 3'd1;
          if (issue_cnt + 3'd1 == ISSUE_LAST) begin
            result_reg <= {bus.cout_in, bus.sum_in};
            valid_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_out        = a_reg;
  assign bus.b_out        = b_reg;
  assign bus.cin_out      = cin_reg;
  assign bus.result       = result_reg;
  assign bus.result_valid = valid_reg;
  assign bus.busy         = busy_reg;

endmodule

`default_nettype wire

// File: tb/tb_adder_serial_loader.sv
// ============================================================================
// tb_adder_serial_loader : directed bench for adder_serial_loader
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_adder_serial_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pulses1 = 0;
  int   pulses3 = 0;

  always #5 clk = ~clk;

  adder_serial_loader_if if1 ();
  adder_serial_loader_if if3 ();

  // Behavioural 3-bit ripple adder in front of each loader
  assign {if1.cout_in, if1.sum_in} = if1.a_out + if1.b_out + if1.cin_out;
  assign {if3.cout_in, if3.sum_in} = if3.a_out + if3.b_out + if3.cin_out;

  adder_serial_loader #(.ISSUE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  adder_serial_loader #(.ISSUE_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if1.result_valid) pulses1 <= pulses1 + 1;
    if (if3.result_valid) pulses3 <= pulses3 + 1;
  end

  task automatic drive1(input logic v, input logic b, input logic fs);
    if1.bit_valid = v; if1.bit_in = b; if1.frame_start = fs;
    @(posedge clk); #1;
    if1.bit_valid = 1'b0; if1.bit_in = 1'b0; if1.frame_start = 1'b0;
  endtask

  task automatic drive3(input logic v, input logic b, input logic fs);
    if3.bit_valid = v; if3.bit_in = b; if3.frame_start = fs;
    @(posedge clk); #1;
    if3.bit_valid = 1'b0; if3.bit_in = 1'b0; if3.frame_start = 1'b0;
  endtask

  // Sends A[0..2], B[0..2], Cin with 'gap' idle cycles between bits; returns after the Cin edge
  task automatic frame1(input logic [2:0] a, input logic [2:0] b, input logic c,
                        input int gap, input logic first_fs);
    logic [6:0] bits;
    bits = {c, b, a};
    for (int i = 0; i < 7; i++) begin
      drive1(1'b1, bits[i], (i == 0) ? first_fs : 1'b0);
      if (i < 6) for (int g = 0; g < gap; g++) drive1(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive1(1'b0, 1'b0, 1'b0);
    checks++;
    if ({if1.a_out, if1.b_out, if1.cin_out, if1.result, if1.result_valid, if1.busy} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {if1.a_out, if1.b_out, if1.cin_out, if1.result, if1.result_valid, if1.busy});
    end
    rst = 1'b0;
    drive1(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    int p0;
    p0 = pulses1;
    frame1(3'd3, 3'd5, 1'b0, 0, 1'b0);
    checks++;
    if (if1.a_out !== 3'd3 || if1.b_out !== 3'd5 || if1.cin_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_operands: got a=%0d b=%0d c=%0d expected a=3 b=5 c=0",
               if1.a_out, if1.b_out, if1.cin_out);
    end
    checks++;
    if (if1.busy !== 1'b1 || if1.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_issue: got busy=%b valid=%b expected busy=1 valid=0",
               if1.busy, if1.result_valid);
    end
    drive1(1'b0, 1'b0, 1'b0);
    checks++;
    if (if1.result_valid !== 1'b1 || if1.result !== 4'd8 || if1.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got valid=%b result=%0d busy=%b expected 1 8 0",
               if1.result_valid, if1.result, if1.busy);
    end
    drive1(1'b0, 1'b0, 1'b0);
    checks++;
    if (if1.result_valid !== 1'b0 || if1.result !== 4'd8 || pulses1 - p0 !== 1) begin
      errors++;
      $display("FAIL basic_pulse: got valid=%b result=%0d pulses=%0d expected 0 8 1",
               if1.result_valid, if1.result, pulses1 - p0);
    end
  endtask

  task automatic test_gaps();
    int p0;
    p0 = pulses1;
    frame1(3'd7, 3'd7, 1'b1, 2, 1'b0);
    checks++;
    if (pulses1 !== p0 || if1.busy !== 1'b1) begin
      errors++;
      $display("FAIL gaps_early: got pulses=%0d busy=%b expected 0 1", pulses1 - p0, if1.busy);
    end
    drive1(1'b0, 1'b0, 1'b0);
    drive1(1'b0, 1'b0, 1'b0);
    checks++;
    if (if1.result !== 4'd15 || pulses1 - p0 !== 1) begin
      errors++;
      $display("FAIL gaps_result: got result=%0d pulses=%0d expected 15 1",
               if1.result, pulses1 - p0);
    end
  endtask

  task automatic test_abort();
    int p0;
    p0 = pulses1;
    drive1(1'b1, 1'b0, 1'b0);
    drive1(1'b1, 1'b1, 1'b0);
    drive1(1'b1, 1'b0, 1'b0);
    drive1(1'b1, 1'b1, 1'b0);
    frame1(3'd1, 3'd1, 1'b1, 0, 1'b1);
    drive1(1'b0, 1'b0, 1'b0);
    drive1(1'b0, 1'b0, 1'b0);
    checks++;
    if (if1.result !== 4'd3 || pulses1 - p0 !== 1) begin
      errors++;
      $display("FAIL abort_result: got result=%0d pulses=%0d expected 3 1",
               if1.result, pulses1 - p0);
    end
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 4; i++) drive1(1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({if1.a_out, if1.b_out, if1.cin_out, if1.result, if1.result_valid, if1.busy} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0",
               {if1.a_out, if1.b_out, if1.cin_out, if1.result, if1.result_valid, if1.busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    frame1(3'd4, 3'd2, 1'b0, 0, 1'b0);
    drive1(1'b0, 1'b0, 1'b0);
    checks++;
    if (if1.result !== 4'd6 || if1.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_recover: got result=%0d valid=%b expected 6 1",
               if1.result, if1.result_valid);
    end
  endtask

  task automatic test_issue3();
    logic [6:0] bits;
    bits = {1'b1, 3'd6, 3'd5};
    for (int i = 0; i < 7; i++) drive3(1'b1, bits[i], 1'b0);
    // Discarded bits would overwrite A[0] with 0 if accepted
    for (int i = 0; i < 2; i++) begin
      drive3(1'b1, 1'b0, 1'b1);
      checks++;
      if (if3.busy !== 1'b1 || if3.result_valid !== 1'b0) begin
        errors++;
        $display("FAIL issue3_busy%0d: got busy=%b valid=%b expected 1 0",
                 i, if3.busy, if3.result_valid);
      end
    end
    drive3(1'b1, 1'b0, 1'b1);
    checks++;
    if (if3.result_valid !== 1'b1 || if3.result !== 4'd12 || if3.busy !== 1'b0) begin
      errors++;
      $display("FAIL issue3_result: got valid=%b result=%0d busy=%b expected 1 12 0",
               if3.result_valid, if3.result, if3.busy);
    end
    checks++;
    if (if3.a_out !== 3'd5 || if3.b_out !== 3'd6 || if3.cin_out !== 1'b1) begin
      errors++;
      $display("FAIL issue3_discard: got a=%0d b=%0d c=%0d expected 5 6 1",
               if3.a_out, if3.b_out, if3.cin_out);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, w;
    frame1(3'd0, 3'd0, 1'b0, 0, 1'b0);
    drive1(1'b0, 1'b0, 1'b0);
    t0 = cyc;
    checks++;
    if (if1.result_valid !== 1'b1 || if1.result !== 4'd0) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b result=%0d expected 1 0",
               if1.result_valid, if1.result);
    end
    frame1(3'd7, 3'd0, 1'b1, 0, 1'b0);
    w = 0;
    drive1(1'b0, 1'b0, 1'b0);
    while (if1.result_valid !== 1'b1 && w < 20) begin
      drive1(1'b0, 1'b0, 1'b0);
      w++;
    end
    t1 = cyc;
    checks++;
    if (if1.result_valid !== 1'b1 || if1.result !== 4'd8 || t1 - t0 !== 8) begin
      errors++;
      $display("FAIL b2b_second: got valid=%b result=%0d spacing=%0d expected 1 8 8",
               if1.result_valid, if1.result, t1 - t0);
    end
  endtask

  initial begin
    if1.bit_valid = 1'b0; if1.bit_in = 1'b0; if1.frame_start = 1'b0;
    if3.bit_valid = 1'b0; if3.bit_in = 1'b0; if3.frame_start = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_abort();
    test_midframe_reset();
    test_issue3();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_serial_loader.md
Name: adder_serial_loader

Overview:
- Upstream/downstream companion of the 3-bit ripple adder.
- Assembles operand A, operand B and carry-in from a bit-serial input stream and drives them as registered signals onto the adder's A/B/C_in inputs.
- Holds those operands stable for a programmable settling window, then registers the adder's {C_out, Sum} as a 4-bit result with a one-cycle valid pulse.
- Sits between the board's serial switch/debounce front-end and the display stage.

Parameters:
- ISSUE_CYCLES, default 1: clock cycles operands are held stable before the result is captured. Legal range 1..7.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial data bit, sampled when bit_valid=1.
- bit_valid  input  1  qualifies bit_in for one clk cycle.
- frame_start  input  1  when high together with bit_valid, bit_in is A[0] of a new frame.
- a_out  output  3  registered operand A, to the adder's A input.
- b_out  output  3  registered operand B, to the adder's B input.
- cin_out  output  1  registered carry-in, to the adder's C_in input.
- sum_in  input  3  adder Sum output (combinational from a_out/b_out/cin_out).
- cout_in  input  1  adder C_out output.
- result  output  4  registered {cout_in, sum_in}.
- result_valid  output  1  one-cycle pulse: result updated this cycle.
- busy  output  1  high while operands are issued; serial input is ignored.

Behaviour:
- Reset (asynchronous, any state, including mid-frame or mid-issue):
  - state=IDLE, bit counter=0, issue counter=0.
  - a_out=0, b_out=0, cin_out=0, result=0, result_valid=0, busy=0.
- Frame format: 7 bits, LSB first, in the order A[0], A[1], A[2], B[0], B[1], B[2], Cin.
- Cycles with bit_valid=0 are gaps: no state change. Gaps of any length are allowed anywhere within a frame.
- States:
  - IDLE: on bit_valid=1, store bit_in as A[0] (frame_start not required); bit counter=1; go to LOAD.
  - LOAD: on bit_valid=1 with frame_start=0, store bit_in at the position given by the bit counter, then increment the counter.
    - Each bit is written directly into its a_out/b_out/cin_out bit; untouched bits keep their prior values.
    - When the Cin bit (counter=6) is stored: issue counter=0; go to ISSUE.
  - LOAD with bit_valid=1 and frame_start=1: abort the current frame. bit_in becomes the new A[0]; bit counter=1; stay in LOAD. No result is produced for the aborted frame.
  - ISSUE: busy=1; a_out/b_out/cin_out held constant; bit_valid and frame_start ignored (bits are discarded, not queued).
    - The issue counter increments each cycle.
    - On the edge where the counter reaches ISSUE_CYCLES: result<={cout_in,sum_in}, result_valid<=1, busy<=0; go to IDLE.
- result_valid is high for exactly one cycle. result holds its value until the next capture or reset.
- Latency: Cin sampled at edge k; result and result_valid registered at edge k+ISSUE_CYCLES.
  - With ISSUE_CYCLES=1: Cin at edge k, result_valid high in cycle k+1 to k+2.
- Back-to-back frames: a bit presented in the cycle result_valid=1 is accepted as A[0] of the next frame (state is already IDLE). Minimum frame period is 7+ISSUE_CYCLES cycles.
- frame_start in IDLE: harmless; treated as a normal first bit.
- frame_start in ISSUE: ignored.
- Width rule: result[3] is cout_in and result[2:0] is sum_in, giving 0..15 for A+B+Cin.
- Outputs are glitch-free registers. The only combinational path is the external adder.

Test Plan:
- Frame 1,1,0,1,0,1,0 (A=3, B=5, Cin=0), ISSUE_CYCLES=1 → a_out=3, b_out=5, cin_out=0; busy=1 for 1 cycle; result=4'b1000 (8); result_valid pulses once, 1 cycle after the Cin edge.
- Frame A=7, B=7, Cin=1 with 2-cycle bit_valid gaps between bits → result=15 (4'b1111); exactly one result_valid pulse; no early capture during gaps.
- Send A=2 and B[0] only, then frame_start=1 with a full frame A=1, B=1, Cin=1 → no pulse for the aborted frame; result=3.
- Assert rst for 1 cycle after 4 bits, then send A=4, B=2, Cin=0 → all outputs 0 immediately on rst; result=6.
- ISSUE_CYCLES=3, A=5, B=6, Cin=1 → busy high for 3 cycles; bit_valid pulses during busy are discarded; result=12 at edge k+3.
- Two back-to-back frames: 0+0+0 then 7+0+1, second frame's first bit in the result_valid cycle → results 0 then 8; two pulses 8 cycles apart.
